// File: rtl/fp_mant_seq_adder.sv
// ============================================================================
// Module   : fp_mant_seq_adder
// Brief    : Multi-cycle mantissa adder/subtractor. Processes CHUNK bits per
//            clock and keeps a registered carry between slices. Uses
//            valid/ready handshakes on the input and output sides.
//            Optional macro FP_MANT_LZC_EN adds a registered leading-zero
//            count of the result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mant_seq_adder #(
    parameter int WIDTH = 24,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef FP_MANT_LZC_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] lzc
`endif
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH % CHUNK) != 0 || CHUNK < 1 || CHUNK > WIDTH) begin : g_param_check
            $error("fp_mant_seq_adder: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_opa;
    logic [WIDTH-1:0]  r_opb;
    logic              r_cy;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;

    logic [CHUNK-1:0]  w_sa;
    logic [CHUNK-1:0]  w_sb;
    logic [CHUNK:0]    w_slice;
    logic [WIDTH-1:0]  w_sum_next;
    logic              w_last;
    logic              w_accept;
    logic              w_release;

    // ------------------------------------------------------------------
    // Slice datapath: select the current operand slice and splice the
    // partial sum into the result word.
    // ------------------------------------------------------------------
    always_comb begin
        w_sa       = '0;
        w_sb       = '0;
        w_sum_next = r_sum;
        for (int s = 0; s < NSLICE; s++) begin
            if (r_idx == IDXW'(s)) begin
                w_sa = r_opa[s*CHUNK +: CHUNK];
                w_sb = r_opb[s*CHUNK +: CHUNK];
            end
        end
        w_slice = {1'b0, w_sa} + {1'b0, w_sb} + {{CHUNK{1'b0}}, r_cy};
        for (int s = 0; s < NSLICE; s++) begin
            if (r_idx == IDXW'(s)) begin
                w_sum_next[s*CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
            end
        end
    end

    assign w_last    = (r_idx == IDXW'(NSLICE - 1));
    assign w_accept  = in_valid && in_ready;
    assign w_release = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture and slice sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_cy    <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opa <= a;
                // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
                r_opb <= sub ? ~b : b;
                r_cy  <= sub;
                r_idx <= '0;
            end else if (r_state == RUN) begin
                r_sum <= w_sum_next;
                r_cy  <= w_slice[CHUNK];
                r_idx <= w_last ? '0 : r_idx + IDXW'(1);
                if (w_last) begin
                    r_carry <= w_slice[CHUNK];
                end
            end
        end
    end

    assign sum   = r_sum;
    assign carry = r_carry;

`ifdef FP_MANT_LZC_EN
    localparam int LZW = $clog2(WIDTH + 1);

    logic [LZW-1:0] w_lzc;
    logic           w_found;
    logic [LZW-1:0] r_lzc;

    // Counted on the final spliced sum so the result is ready with out_valid.
    always_comb begin
        w_lzc   = LZW'(WIDTH);
        w_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!w_found && w_sum_next[i]) begin
                w_lzc   = LZW'(WIDTH - 1 - i);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lzc <= '0;
        end else if (r_state == RUN && w_last) begin
            r_lzc <= w_lzc;
        end
    end

    assign lzc = r_lzc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_mant_seq_adder.sv
// ============================================================================
// Module   : tb_fp_mant_seq_adder
// Brief    : Directed self-checking bench for fp_mant_seq_adder, WIDTH=12,
//            CHUNK=4. LZC checks are included when FP_MANT_LZC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mant_seq_adder;

    localparam int c_width = 12;
    localparam int c_chunk = 4;
    localparam int c_nslice = c_width / c_chunk;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [c_width-1:0]  a;
    logic [c_width-1:0]  b;
    logic                sub;
    logic                out_valid;
    logic                out_ready;
    logic [c_width-1:0]  sum;
    logic                carry;
`ifdef FP_MANT_LZC_EN
    logic [$clog2(c_width+1)-1:0] lzc;
`endif

    int n_vec = 0;
    int n_bad = 0;

    fp_mant_seq_adder #(
        .WIDTH (c_width),
        .CHUNK (c_chunk)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
`ifdef FP_MANT_LZC_EN
        ,
        .lzc       (lzc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation; junk is driven on the inputs while busy.
    task automatic do_op(input string tag, input logic [11:0] va, input logic [11:0] vb,
                         input logic vsub, input logic [11:0] esum, input logic ecy,
                         input int elzc, input int hold);
        int lat;
        logic [11:0] s_hold;
        logic        c_hold;
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = va;
        b = vb;
        sub = vsub;
        tick();
        a = 12'($urandom);
        b = 12'($urandom);
        sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            check({tag, ".in_ready_run"}, 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(c_nslice));
        check({tag, ".sum"}, 32'(sum), 32'(esum));
        check({tag, ".carry"}, 32'(carry), 32'(ecy));
`ifdef FP_MANT_LZC_EN
        check({tag, ".lzc"}, 32'(lzc), 32'(elzc));
`else
        if (elzc < 0) $display("note: negative lzc argument in %s", tag);
`endif
        s_hold = sum;
        c_hold = carry;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".hold_sum"}, 32'(sum), 32'(esum));
            check({tag, ".hold_carry"}, 32'(carry), 32'(ecy));
            if (sum !== s_hold || carry !== c_hold) begin
                check({tag, ".hold_stable"}, 32'(sum), 32'(s_hold));
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".post_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.sum", 32'(sum), 32'd0);
        check("reset.carry", 32'(carry), 32'd0);
`ifdef FP_MANT_LZC_EN
        check("reset.lzc", 32'(lzc), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Stray out_ready in IDLE must not disturb anything.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle.out_valid", 32'(out_valid), 32'd0);

        do_op("add_7ff_1", 12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 0, 0);
        do_op("add_fff_1", 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 12, 0);
        do_op("sub_5_7",   12'h005, 12'h007, 1'b1, 12'hFFE, 1'b0, 0, 0);
        do_op("sub_7_5",   12'h007, 12'h005, 1'b1, 12'h002, 1'b1, 10, 0);
        do_op("add_abc",   12'hABC, 12'h543, 1'b0, 12'hFFF, 1'b0, 0, 0);
        do_op("add_800",   12'h800, 12'h800, 1'b0, 12'h000, 1'b1, 12, 0);
        do_op("sub_equal", 12'h3C3, 12'h3C3, 1'b1, 12'h000, 1'b1, 12, 0);
        do_op("backpress", 12'h0F0, 12'h00F, 1'b0, 12'h0FF, 1'b0, 4, 5);
        do_op("lzc_0_1",   12'h000, 12'h001, 1'b0, 12'h001, 1'b0, 11, 0);
        do_op("lzc_0_0",   12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 12, 0);
        do_op("lzc_400",   12'h400, 12'h400, 1'b0, 12'h800, 1'b0, 0, 0);

        // Abort after the first slice has been written.
        in_valid = 1'b1;
        a = 12'hFFF;
        b = 12'hFFF;
        sub = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.sum", 32'(sum), 32'd0);
        check("midrst.carry", 32'(carry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst.no_pending", 32'(out_valid), 32'd0);
        end
        do_op("after_rst", 12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
